// File: rtl/nn_pkg.sv
// Shared types, default sizes and requantisation helpers for the layer sequencer.
package nn_pkg;

    localparam int unsigned DefW    = 16;
    localparam int unsigned DefAccW = 32;
    localparam int unsigned DefFrac = 12;
    localparam int unsigned DefDim  = 16;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StWb,
        StResp
    } state_e;

    // Layer-index width, never narrower than one bit.
    function automatic int unsigned layer_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Arithmetic shift right by frac, then clamp to the signed w-bit range.
    function automatic logic signed [63:0] requant_sat(input logic signed [63:0] x,
                                                       input int unsigned frac,
                                                       input int unsigned w);
        logic signed [63:0] q;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        q  = x >>> frac;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (q > hi) begin
            return hi;
        end else if (q < lo) begin
            return lo;
        end
        return q;
    endfunction

    function automatic logic signed [63:0] relu(input logic signed [63:0] x);
        return (x < 0) ? 64'sd0 : x;
    endfunction

endpackage

// File: rtl/nn_requant.sv
// DIM-wide combinational requantise (shift + saturate) with optional ReLU.
module nn_requant
    import nn_pkg::*;
#(
    parameter int unsigned W     = DefW,
    parameter int unsigned ACC_W = DefAccW,
    parameter int unsigned FRAC  = DefFrac,
    parameter int unsigned DIM   = DefDim
) (
    input  logic [DIM*ACC_W-1:0] i_res,
    input  logic                 i_relu,
    output logic [DIM*W-1:0]     o_act
);

    logic signed [63:0] w_v;

    // Per-element shift, clamp and optional rectification.
    always_comb begin
        o_act = '0;
        w_v   = '0;
        for (int i = 0; i < DIM; i++) begin
            w_v = 64'(signed'(i_res[i*ACC_W +: ACC_W]));
            w_v = requant_sat(w_v, FRAC, W);
            if (i_relu) begin
                w_v = relu(w_v);
            end
            o_act[i*W +: W] = W'(w_v);
        end
    end

endmodule

// File: rtl/nn_layer_sched.sv
// Layer-by-layer inference sequencer driving a shared matrix-vector engine.
// Optional engine watchdog enabled by defining NN_LAYER_SCHED_WATCHDOG_EN.
module nn_layer_sched
    import nn_pkg::*;
#(
    parameter int unsigned W       = DefW,
    parameter int unsigned ACC_W   = DefAccW,
    parameter int unsigned FRAC    = DefFrac,
    parameter int unsigned DIM     = DefDim,
    parameter int unsigned NLAYERS = 3
`ifdef NN_LAYER_SCHED_WATCHDOG_EN
    ,
    parameter int unsigned TIMEOUT = 1024
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_req_valid,
    output logic                         o_req_ready,
    input  logic [W-1:0]                 i_req_data,
    output logic                         o_rsp_valid,
    input  logic                         i_rsp_ready,
    output logic [W-1:0]                 o_rsp_data,
    output logic                         o_rsp_err,
    output logic                         o_busy,
    output logic                         o_eng_start,
    output logic [layer_w(NLAYERS)-1:0]  o_eng_layer,
    output logic [DIM*W-1:0]             o_eng_vec,
    input  logic                         i_eng_done,
    input  logic [DIM*ACC_W-1:0]         i_eng_res
);

    localparam int unsigned     LW        = layer_w(NLAYERS);
    localparam logic [LW-1:0]   LastLayer = LW'(NLAYERS - 1);

    state_e             r_state;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [W-1:0]       r_rsp_data;
    logic               r_busy;
    logic               r_eng_start;
    logic [LW-1:0]      r_layer;
    logic [DIM*W-1:0]   r_act;

    logic [DIM*W-1:0]   w_act_relu;
    logic [W-1:0]       w_final0;

`ifdef NN_LAYER_SCHED_WATCHDOG_EN
    localparam int unsigned   WdW    = $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);
    logic               r_rsp_err;
    logic [WdW-1:0]     r_wdog;
    assign o_rsp_err = r_rsp_err;
`else
    assign o_rsp_err = 1'b0;
`endif

    // Hidden-layer activations are always rectified.
    nn_requant #(
        .W    (W),
        .ACC_W(ACC_W),
        .FRAC (FRAC),
        .DIM  (DIM)
    ) u_requant (
        .i_res (i_eng_res),
        .i_relu(1'b1),
        .o_act (w_act_relu)
    );

    // Final-layer element 0 keeps its sign (no ReLU).
    assign w_final0 = W'(requant_sat(64'(signed'(i_eng_res[ACC_W-1:0])), FRAC, W));

    assign o_req_ready = r_req_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = r_busy;
    assign o_eng_start = r_eng_start;
    assign o_eng_layer = r_layer;
    assign o_eng_vec   = r_act;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_busy      <= 1'b0;
            r_eng_start <= 1'b0;
            r_layer     <= '0;
            r_act       <= '0;
`ifdef NN_LAYER_SCHED_WATCHDOG_EN
            r_rsp_err   <= 1'b0;
            r_wdog      <= '0;
`endif
        end else begin
            r_eng_start <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_req_valid) begin
                        r_act       <= {{((DIM - 1) * W){1'b0}}, i_req_data};
                        r_layer     <= '0;
                        r_eng_start <= 1'b1;
                        r_req_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= StIssue;
                    end
                end
                StIssue: begin
`ifdef NN_LAYER_SCHED_WATCHDOG_EN
                    r_wdog  <= '0;
`endif
                    r_state <= StWait;
                end
                StWait: begin
                    if (i_eng_done) begin
                        r_state <= StWb;
                    end
`ifdef NN_LAYER_SCHED_WATCHDOG_EN
                    else if (r_wdog == WdLast) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= '0;
                        r_rsp_err   <= 1'b1;
                        r_state     <= StResp;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
`endif
                end
                StWb: begin
                    if (r_layer != LastLayer) begin
                        r_act       <= w_act_relu;
                        r_layer     <= r_layer + 1'b1;
                        r_eng_start <= 1'b1;
                        r_state     <= StIssue;
                    end else begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= w_final0;
`ifdef NN_LAYER_SCHED_WATCHDOG_EN
                        r_rsp_err   <= 1'b0;
`endif
                        r_state     <= StResp;
                    end
                end
                StResp: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_layer_sched.sv
// Scoreboard bench for nn_layer_sched with a fixed-latency engine model.
module tb_nn_layer_sched;

    localparam int W     = 16;
    localparam int ACC_W = 32;
    localparam int FRAC  = 12;
    localparam int DIM   = 16;
    localparam int NL    = 3;
    localparam int LW    = 2;
    localparam int ENG_L = 3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               req_valid = 1'b0;
    logic               req_ready;
    logic [W-1:0]       req_data = '0;
    logic               rsp_valid;
    logic               rsp_ready = 1'b1;
    logic [W-1:0]       rsp_data;
    logic               rsp_err;
    logic               busy;
    logic               eng_start;
    logic [LW-1:0]      eng_layer;
    logic [DIM*W-1:0]   eng_vec;
    logic               eng_done_m = 1'b0;
    logic               stale_done = 1'b0;
    logic [DIM*ACC_W-1:0] eng_res = '0;

    logic [DIM*ACC_W-1:0] res_tab [NL];
    int                 eng_cnt = 0;
    logic [LW-1:0]      eng_lq = '0;
    bit                 eng_en = 1'b1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cyc = 0;

    typedef struct { logic [15:0] data; logic err; int lat; } rsp_t;
    typedef struct { int layer; logic [15:0] v0; logic [15:0] v3; bit chkv; } st_t;
    rsp_t exp_q[$];
    st_t  st_q[$];

    always #5 clk = ~clk;

    nn_layer_sched #(
        .W      (W),
        .ACC_W  (ACC_W),
        .FRAC   (FRAC),
        .DIM    (DIM),
        .NLAYERS(NL)
`ifdef NN_LAYER_SCHED_WATCHDOG_EN
        ,
        .TIMEOUT(8)
`endif
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_req_valid(req_valid),
        .o_req_ready(req_ready),
        .i_req_data (req_data),
        .o_rsp_valid(rsp_valid),
        .i_rsp_ready(rsp_ready),
        .o_rsp_data (rsp_data),
        .o_rsp_err  (rsp_err),
        .o_busy     (busy),
        .o_eng_start(eng_start),
        .o_eng_layer(eng_layer),
        .o_eng_vec  (eng_vec),
        .i_eng_done (eng_done_m | stale_done),
        .i_eng_res  (eng_res)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: done pulses on the 3rd edge after the edge that samples start.
    always @(posedge clk) begin
        eng_done_m <= 1'b0;
        if (eng_start && eng_en) begin
            eng_cnt <= ENG_L;
            eng_lq  <= eng_layer;
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                eng_done_m <= 1'b1;
                eng_res    <= res_tab[eng_lq];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_tab(input int l, input logic [31:0] e0, input logic [31:0] e3);
        res_tab[l] = '0;
        res_tab[l][0 +: 32]  = e0;
        res_tab[l][96 +: 32] = e3;
    endtask

    task automatic push_start(input int l, input logic [15:0] v0, input logic [15:0] v3,
                              input bit chkv);
        st_t s;
        s.layer = l; s.v0 = v0; s.v3 = v3; s.chkv = chkv;
        st_q.push_back(s);
    endtask

    task automatic push_rsp(input logic [15:0] d, input logic e, input int lat);
        rsp_t r;
        r.data = d; r.err = e; r.lat = lat;
        exp_q.push_back(r);
    endtask

    task automatic drive_req(input logic [15:0] d);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b1;
        req_data  = d;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (req_ready) begin
                acc_cyc = cyc + 1;
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL req_accept_timeout: got 0 expected 1");
        end
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && req_ready && !rsp_valid) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout: got busy expected idle", name);
        end
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_data"}, {16'd0, rsp_data}, 32'd0);
        chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_eng_start"}, {31'd0, eng_start}, 32'd0);
        chk({tag, "_eng_layer"}, {30'd0, eng_layer}, 32'd0);
        chk({tag, "_eng_vec_zero"}, {31'd0, (eng_vec == '0)}, 32'd1);
    endtask

    // Response monitor: pops on each completed handshake.
    initial begin
        int first_cyc;
        bit prev_v;
        rsp_t r;
        first_cyc = 0;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (rsp_valid && !prev_v) first_cyc = cyc;
            prev_v = rsp_valid;
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got data %0h expected no response", rsp_data);
                end else begin
                    r = exp_q.pop_front();
                    chk("rsp_data", {16'd0, rsp_data}, {16'd0, r.data});
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, r.err});
                    if (r.lat >= 0) chk("rsp_latency", first_cyc - acc_cyc + 1, r.lat);
                end
            end
        end
    end

    // Start monitor: one expected entry per engine start pulse.
    initial begin
        st_t s;
        forever begin
            @(negedge clk);
            if (eng_start) begin
                if (st_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL start_unexpected: got layer %0d expected no start", eng_layer);
                end else begin
                    s = st_q.pop_front();
                    chk("eng_layer", {30'd0, eng_layer}, s.layer);
                    if (s.chkv) begin
                        chk("eng_vec0", {16'd0, eng_vec[0 +: 16]}, {16'd0, s.v0});
                        chk("eng_vec3", {16'd0, eng_vec[48 +: 16]}, {16'd0, s.v3});
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    task automatic basic_tabs();
        for (int l = 0; l < NL; l++) set_tab(l, 32'sh0001_2000, 32'h0);
    endtask

    initial begin
        int bad;
        bit seen;
        bit ok;
        for (int l = 0; l < NL; l++) res_tab[l] = '0;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outs("reset");

        // Nominal three-layer run.
        basic_tabs();
        push_start(0, 16'h0100, 16'h0, 1'b1);
        push_start(1, 16'h0012, 16'h0, 1'b1);
        push_start(2, 16'h0012, 16'h0, 1'b1);
        push_rsp(16'h0012, 1'b0, 19);
        drive_req(16'sh0100);
        @(negedge clk);
        chk("busy_running", {31'd0, busy}, 32'd1);
        chk("req_ready_running", {31'd0, req_ready}, 32'd0);
        wait_idle("nominal");

        // Positive saturation on the final layer.
        basic_tabs();
        set_tab(2, 32'sh0800_0000, 32'h0);
        for (int l = 0; l < NL; l++) push_start(l, 16'h0, 16'h0, 1'b0);
        push_rsp(16'h7FFF, 1'b0, 19);
        drive_req(16'sh0001);
        wait_idle("sat_hi");

        // Negative saturation on the final layer.
        basic_tabs();
        set_tab(2, 32'shF000_0000, 32'h0);
        for (int l = 0; l < NL; l++) push_start(l, 16'h0, 16'h0, 1'b0);
        push_rsp(16'h8000, 1'b0, 19);
        drive_req(16'sh0002);
        wait_idle("sat_lo");

        // ReLU on hidden layers, none on the final element.
        set_tab(0, 32'sh0001_2000, 32'shFFFF_0000);
        set_tab(1, 32'sh0001_2000, 32'sh0000_5000);
        set_tab(2, 32'shFFFF_0000, 32'h0);
        push_start(0, 16'hFF80, 16'h0, 1'b1);
        push_start(1, 16'h0012, 16'h0, 1'b1);
        push_start(2, 16'h0012, 16'h0005, 1'b1);
        push_rsp(16'hFFF0, 1'b0, 19);
        drive_req(16'shFF80);
        wait_idle("relu");

        // Response backpressure.
        basic_tabs();
        rsp_ready = 1'b0;
        for (int l = 0; l < NL; l++) push_start(l, 16'h0, 16'h0, 1'b0);
        push_rsp(16'h0012, 1'b0, 19);
        drive_req(16'sh0003);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; break; end
        end
        chk("bp_valid_seen", {31'd0, ok}, 32'd1);
        for (int n = 0; n < 10; n++) begin
            if (n > 0) @(negedge clk);
            chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            chk("bp_rsp_data", {16'd0, rsp_data}, 32'h0012);
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_req_ready_after", {31'd0, req_ready}, 32'd1);
        chk("bp_rsp_valid_after", {31'd0, rsp_valid}, 32'd0);
        chk("bp_queue_drained", exp_q.size(), 0);

        // Reset during layer-1 WAIT; the in-flight done must be ignored.
        basic_tabs();
        push_start(0, 16'h0, 16'h0, 1'b0);
        push_start(1, 16'h0, 16'h0, 1'b0);
        drive_req(16'sh0004);
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (eng_start && eng_layer == 2'd1) begin ok = 1'b1; break; end
        end
        chk("rst_layer1_seen", {31'd0, ok}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outs("midrst");
        bad = 0;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (eng_done_m) seen = 1'b1;
            if (busy || rsp_valid || !req_ready || eng_start) bad++;
        end
        chk("midrst_done_arrived", {31'd0, seen}, 32'd1);
        chk("midrst_done_ignored", bad, 0);

        // Normal request after the abort.
        basic_tabs();
        push_start(0, 16'h0100, 16'h0, 1'b1);
        push_start(1, 16'h0012, 16'h0, 1'b1);
        push_start(2, 16'h0012, 16'h0, 1'b1);
        push_rsp(16'h0012, 1'b0, 19);
        drive_req(16'sh0100);
        wait_idle("post_rst");

`ifdef NN_LAYER_SCHED_WATCHDOG_EN
        // Engine never answers: watchdog aborts after 8 WAIT cycles.
        eng_en = 1'b0;
        push_start(0, 16'h0, 16'h0, 1'b0);
        push_rsp(16'h0000, 1'b1, 10);
        drive_req(16'sh0005);
        wait_idle("watchdog");
        eng_en = 1'b1;
`endif

        // A stray done while idle must not start anything.
        @(posedge clk); #1;
        stale_done = 1'b1;
        @(posedge clk); #1;
        stale_done = 1'b0;
        bad = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (busy || rsp_valid || !req_ready) bad++;
        end
        chk("stale_done_ignored", bad, 0);

        chk("start_queue_empty", st_q.size(), 0);
        chk("rsp_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
